// File: rtl/vliw_pkg.sv
// Shared pipeline-control types: stall-controller states and stall cause codes.
package vliw_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        ALU_WAIT = 2'b01,
        MEM_WAIT = 2'b10,
        HALT     = 2'b11
    } stall_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_ALU  = 2'b01,
        CAUSE_MEM  = 2'b10,
        CAUSE_HALT = 2'b11
    } stall_cause_e;

    localparam int STALL_LEN_W = 5;

endpackage

// File: rtl/stall_perf_cnt.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
module stall_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/stall_ctl.sv
// Global pipeline stall merge with stall-length watchdog.
// Optional stall-cycle performance counters are built when STALL_PERF_EN is defined.
module stall_ctl
    import vliw_pkg::*;
#(
    parameter int NLANE    = 4,
    parameter int WD_LIMIT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NLANE-1:0]       alu_stall,
    input  logic                   mem_stall,
    output logic                   stall,
    output logic [1:0]             stall_cause,
    output logic [STALL_LEN_W-1:0] stall_len,
    output logic                   wd_err
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]            perf_alu_cyc,
    output logic [31:0]            perf_mem_cyc
`endif
);

    localparam logic [STALL_LEN_W-1:0] LEN_MAX = {STALL_LEN_W{1'b1}};
    localparam logic [STALL_LEN_W-1:0] WD_TRIP = STALL_LEN_W'(WD_LIMIT - 1);

    stall_state_e             state_reg, state_next;
    logic [STALL_LEN_W-1:0]   stall_len_reg, stall_len_next;
    logic                     wd_err_reg, wd_err_next;
    stall_cause_e             cause_c;
    logic                     alu_req;
    logic                     halted;

    // Stall is purely combinational: lanes act on it in the same cycle.
    always_comb begin
        alu_req = |alu_stall;
        halted  = (state_reg == HALT);
        stall   = alu_req | mem_stall | halted;

        cause_c = CAUSE_NONE;
        if (halted)
            cause_c = CAUSE_HALT;
        else if (mem_stall)
            cause_c = CAUSE_MEM;
        else if (alu_req)
            cause_c = CAUSE_ALU;
    end

    assign stall_cause = cause_c;

    always_comb begin
        state_next     = state_reg;
        stall_len_next = '0;
        wd_err_next    = wd_err_reg;

        if (stall)
            stall_len_next = (stall_len_reg == LEN_MAX) ? LEN_MAX : stall_len_reg + 1'b1;

        if (halted) begin
            state_next = HALT;
        end else if (stall && (stall_len_reg == WD_TRIP)) begin
            state_next  = HALT;
            wd_err_next = 1'b1;
        end else if (mem_stall) begin
            state_next = MEM_WAIT;
        end else if (alu_req) begin
            state_next = ALU_WAIT;
        end else begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            stall_len_reg <= '0;
            wd_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            stall_len_reg <= stall_len_next;
            wd_err_reg    <= wd_err_next;
        end
    end

    assign stall_len = stall_len_reg;
    assign wd_err    = wd_err_reg;

`ifdef STALL_PERF_EN
    logic alu_inc;
    logic mem_inc;

    // HALT cycles report CAUSE_HALT, so they are excluded from both counts.
    assign alu_inc = (cause_c == CAUSE_ALU);
    assign mem_inc = (cause_c == CAUSE_MEM);

    stall_perf_cnt #(.WIDTH(32)) u_perf_alu (
        .clk   (clk),
        .rst   (rst),
        .inc   (alu_inc),
        .count (perf_alu_cyc)
    );

    stall_perf_cnt #(.WIDTH(32)) u_perf_mem (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_inc),
        .count (perf_mem_cyc)
    );
`endif

endmodule

// File: tb/tb_stall_ctl.sv
// Directed bench for stall_ctl: stall merge, cause priority, stall_len, watchdog and reset.
module tb_stall_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] alu_stall;
    logic       mem_stall;
    logic       stall;
    logic [1:0] stall_cause;
    logic [4:0] stall_len;
    logic       wd_err;
`ifdef STALL_PERF_EN
    logic [31:0] perf_alu_cyc;
    logic [31:0] perf_mem_cyc;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stall_ctl #(.NLANE(4), .WD_LIMIT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_stall   (alu_stall),
        .mem_stall   (mem_stall),
        .stall       (stall),
        .stall_cause (stall_cause),
        .stall_len   (stall_len),
        .wd_err      (wd_err)
`ifdef STALL_PERF_EN
        ,
        .perf_alu_cyc(perf_alu_cyc),
        .perf_mem_cyc(perf_mem_cyc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Apply inputs mid-cycle; outputs are sampled 1 time unit later, well away from posedge.
    task automatic step(input logic r, input logic [3:0] a, input logic m);
        @(negedge clk);
        rst       = r;
        alu_stall = a;
        mem_stall = m;
        #1;
        $display("t=%0t rst=%0b alu=%b mem=%0b -> stall=%0b cause=%b len=%0d wd=%0b",
                 $time, r, a, m, stall, stall_cause, stall_len, wd_err);
    endtask

    task automatic chk_all(input string tag, input logic s, input logic [1:0] c,
                           input logic [4:0] l, input logic w);
        chk({tag, ".stall"}, 32'(stall), 32'(s));
        chk({tag, ".cause"}, 32'(stall_cause), 32'(c));
        chk({tag, ".len"},   32'(stall_len), 32'(l));
        chk({tag, ".wd"},    32'(wd_err), 32'(w));
    endtask

    initial begin
        rst = 1'b1; alu_stall = '0; mem_stall = 1'b0;
        step(1, 4'b0000, 0);
        step(1, 4'b0000, 0);
        step(0, 4'b0000, 0);
        chk_all("reset", 0, 2'b00, 0, 0);
`ifdef STALL_PERF_EN
        chk("reset.perf_alu", perf_alu_cyc, 0);
        chk("reset.perf_mem", perf_mem_cyc, 0);
`endif

        // Single-cycle ALU op
        step(0, 4'b0001, 0); chk_all("alu1.c0", 1, 2'b01, 0, 0);
        step(0, 4'b0000, 0); chk_all("alu1.c1", 0, 2'b00, 1, 0);
        step(0, 4'b0000, 0); chk_all("alu1.c2", 0, 2'b00, 0, 0);

        // ALU run with MEM overlapping the middle cycle
        step(0, 4'b0100, 0); chk_all("ovl.c0", 1, 2'b01, 0, 0);
        step(0, 4'b0100, 1); chk_all("ovl.c1", 1, 2'b10, 1, 0);
        step(0, 4'b0100, 0); chk_all("ovl.c2", 1, 2'b01, 2, 0);
        step(0, 4'b0000, 0); chk_all("ovl.c3", 0, 2'b00, 3, 0);
`ifdef STALL_PERF_EN
        chk("ovl.perf_alu", perf_alu_cyc, 3);
        chk("ovl.perf_mem", perf_mem_cyc, 1);
`endif
        step(0, 4'b0000, 0); chk("ovl.len0", 32'(stall_len), 0);

        // Lane hand-off mid-run counts as one continuous stall
        step(0, 4'b0001, 0); chk_all("lane.c0", 1, 2'b01, 0, 0);
        step(0, 4'b1000, 0); chk_all("lane.c1", 1, 2'b01, 1, 0);
        step(0, 4'b0000, 1); chk_all("lane.c2", 1, 2'b10, 2, 0);
        step(0, 4'b0000, 0); chk_all("lane.c3", 0, 2'b00, 3, 0);
        step(0, 4'b0000, 0);

        // 15-cycle MEM stall must not trip the watchdog
        for (int i = 0; i < 15; i++) begin
            step(0, 4'b0000, 1);
            chk_all($sformatf("mem15.c%0d", i), 1, 2'b10, 5'(i), 0);
        end
        step(0, 4'b0000, 0); chk_all("mem15.end", 0, 2'b00, 15, 0);
        step(0, 4'b0000, 0); chk_all("mem15.idle", 0, 2'b00, 0, 0);
`ifdef STALL_PERF_EN
        chk("mem15.perf_alu", perf_alu_cyc, 5);
        chk("mem15.perf_mem", perf_mem_cyc, 17);
`endif

        // 16-cycle MEM stall trips the watchdog on the 16th edge
        for (int i = 0; i < 16; i++) begin
            step(0, 4'b0000, 1);
            chk_all($sformatf("mem16.c%0d", i), 1, 2'b10, 5'(i), 0);
        end
        step(0, 4'b0000, 0); chk_all("halt.c0", 1, 2'b11, 16, 1);
        step(0, 4'b0011, 1); chk_all("halt.c1", 1, 2'b11, 17, 1);
        for (int i = 0; i < 16; i++) step(0, 4'b0010, 0);
        chk_all("halt.sat", 1, 2'b11, 31, 1);
`ifdef STALL_PERF_EN
        chk("halt.perf_alu", perf_alu_cyc, 5);
        chk("halt.perf_mem", perf_mem_cyc, 33);
`endif

        // Reset out of HALT: stall still reflects HALT until the edge
        step(1, 4'b0000, 0); chk("rsthalt.stall", 32'(stall), 1);
        step(0, 4'b0000, 0); chk_all("rsthalt.after", 0, 2'b00, 0, 0);
`ifdef STALL_PERF_EN
        chk("rsthalt.perf_alu", perf_alu_cyc, 0);
        chk("rsthalt.perf_mem", perf_mem_cyc, 0);
`endif

        // Reset mid-stall: stall stays combinational, length cleared on the edge
        step(0, 4'b0000, 1); chk_all("rstmid.c0", 1, 2'b10, 0, 0);
        step(1, 4'b0001, 0); chk_all("rstmid.c1", 1, 2'b01, 1, 0);
        step(0, 4'b0000, 0); chk_all("rstmid.c2", 0, 2'b00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
